ahb_xfer_sequencer: RTL and testbench
=====================================

AHB_XFER_SEQUENCER -- requirements
Module: ahb_xfer_sequencer

Interface
REQ-001 SHALL have parameter BUS_WDT, default 32, meaning data width (32 or 64 only).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning entries per data FIFO (power of 2, >=4).
REQ-003 SHALL have port i_hclk, input, 1, clock; all state changes on its rising edge.
REQ-004 SHALL have port i_hreset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports i_cmd_valid in 1, o_cmd_ready out 1, i_cmd_addr in 32, i_cmd_len in 16 (beats), i_cmd_size in 2, i_cmd_write in 1, i_cmd_prot in 4, i_cmd_lock in 1: burst command.
REQ-006 SHALL have ports i_wr_data in BUS_WDT, i_wr_valid in 1, o_wr_ready out 1: write-data stream.
REQ-007 SHALL have ports o_rd_data out BUS_WDT, o_rd_valid out 1, i_rd_ready in 1: read-data stream.
REQ-008 SHALL have ports o_xfer_wdata/addr/size/dav/trig/en/write/prot/lock/full (out, widths BUS_WDT/32/2/1/1/1/1/4/1/1) driving the AHB master UI.
REQ-009 SHALL have ports i_xfer_adv in 1, i_xfer_rdata in BUS_WDT, i_xfer_rdav in 1 from the AHB master.
REQ-010 SHALL have ports o_busy out 1 (state != IDLE), o_done out 1 (one-cycle completion pulse).

Function
REQ-011 SHALL implement FSM IDLE, TRIG, RUN, DRAIN.
REQ-012 IDLE: o_cmd_ready=1, o_xfer_en=0; on i_cmd_valid, latch addr/len/size/write/prot/lock; len==0 -> o_done next cycle, stay IDLE; else -> TRIG.
REQ-013 TRIG: o_xfer_en=1, o_xfer_trig=1, o_xfer_addr=latched addr; beat issued when i_xfer_adv && beat-ready; -> RUN, or DRAIN if len==1.
REQ-014 RUN: o_xfer_en=1, o_xfer_trig=0; each i_xfer_adv && beat-ready increments issued count; issued==len -> DRAIN on that edge.
REQ-015 Beat-ready: write = write FIFO non-empty; read = o_xfer_full low.
REQ-016 o_xfer_dav SHALL equal write FIFO non-empty; o_xfer_wdata SHALL be write FIFO head (combinational, first-word-fall-through).
REQ-017 Write FIFO SHALL pop exactly once per issued write beat; never pop empty.
REQ-018 o_xfer_full SHALL assert when read FIFO occupancy >= FIFO_DEPTH-1 (one slot reserved for in-flight data phase).
REQ-019 Every i_xfer_rdav SHALL push i_xfer_rdata into read FIFO and increment received count; push when full is a design error (assertion).
REQ-020 DRAIN: o_xfer_en=0; write -> wait one i_xfer_adv (final data phase); read -> wait received==len; then o_done=1 for one cycle, -> IDLE.
REQ-021 o_xfer_write/size/prot/lock SHALL hold latched command values from TRIG through DRAIN.
REQ-022 Counters SHALL be 16-bit, no wrap; len 65535 supported.
REQ-023 Simultaneous FIFO push and pop SHALL keep occupancy constant; o_wr_ready = write FIFO not full; o_rd_valid = read FIFO non-empty.
REQ-024 RETRY/SPLIT replay is owned by the master; i_xfer_adv low stalls counting, no beat lost or duplicated.

Reset
REQ-025 On i_hreset_n low (any time, incl. mid-burst): state IDLE, counters 0, FIFOs empty, o_done/o_xfer_en/o_xfer_trig/o_rd_valid/o_busy 0, o_cmd_ready/o_wr_ready 1, latched fields 0.
REQ-026 Reset deassertion SHALL need no extra cycles; command accepted in first cycle after.

Structure
REQ-027 FSM state encodings and FIFO_DEPTH default SHALL live in shared package ahb_master_pkg.
REQ-028 Both FIFOs SHALL be instances of one sub-module ahb_sync_fifo (WDT, DEPTH; push/pop/full/empty/count).

Verification
REQ-029 Write len=4, addr 0x100, size 2, FIFO preloaded, adv=1 -> trig 1 cycle, 4 pops, o_done 5 cycles after TRIG.
REQ-030 Read len=8, i_rd_ready=0, DEPTH 8 -> o_xfer_full at occupancy 7, no overflow; release -> 8 words in order, o_done.
REQ-031 Write len=3, write FIFO empty after beat 1 -> o_xfer_dav=0, no pop, resumes when data arrives; exactly 3 pops.
REQ-032 len=0 command -> o_done one cycle later, o_xfer_en never asserted.
REQ-033 i_xfer_adv low 3 cycles mid-read (RETRY) -> issued count frozen, total rdav=len.
REQ-034 Reset in RUN beat 2 of 4 -> all REQ-025 values next cycle; new command proceeds normally.

Source files
------------

// File: rtl/ahb_master_pkg.sv
// Shared definitions for the AHB master-side sequencer: FSM encodings, the
// latched burst command record and default sizing.
package ahb_master_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned CNT_WDT        = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRIG  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [31:0]        addr;
    logic [CNT_WDT-1:0] len;
    logic [1:0]         size;
    logic               write;
    logic [3:0]         prot;
    logic               lock;
  } seq_cmd_t;

endpackage

// File: rtl/ahb_xfer_sequencer_if.sv
// Bundle of the sequencer's command, data-stream and AHB master UI signals.
// Names are from the sequencer's point of view; slave = sequencer, master = its driver.
interface ahb_xfer_sequencer_if #(
  parameter int BUS_WDT = 32
);

  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [31:0]        i_cmd_addr;
  logic [15:0]        i_cmd_len;
  logic [1:0]         i_cmd_size;
  logic               i_cmd_write;
  logic [3:0]         i_cmd_prot;
  logic               i_cmd_lock;

  logic [BUS_WDT-1:0] i_wr_data;
  logic               i_wr_valid;
  logic               o_wr_ready;

  logic [BUS_WDT-1:0] o_rd_data;
  logic               o_rd_valid;
  logic               i_rd_ready;

  logic [BUS_WDT-1:0] o_xfer_wdata;
  logic [31:0]        o_xfer_addr;
  logic [1:0]         o_xfer_size;
  logic               o_xfer_dav;
  logic               o_xfer_trig;
  logic               o_xfer_en;
  logic               o_xfer_write;
  logic [3:0]         o_xfer_prot;
  logic               o_xfer_lock;
  logic               o_xfer_full;

  logic               i_xfer_adv;
  logic [BUS_WDT-1:0] i_xfer_rdata;
  logic               i_xfer_rdav;

  logic               o_busy;
  logic               o_done;

  modport slave (
    input  i_cmd_valid, i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_write,
           i_cmd_prot, i_cmd_lock, i_wr_data, i_wr_valid, i_rd_ready,
           i_xfer_adv, i_xfer_rdata, i_xfer_rdav,
    output o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid, o_xfer_wdata,
           o_xfer_addr, o_xfer_size, o_xfer_dav, o_xfer_trig, o_xfer_en,
           o_xfer_write, o_xfer_prot, o_xfer_lock, o_xfer_full, o_busy, o_done
  );

  modport master (
    output i_cmd_valid, i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_write,
           i_cmd_prot, i_cmd_lock, i_wr_data, i_wr_valid, i_rd_ready,
           i_xfer_adv, i_xfer_rdata, i_xfer_rdav,
    input  o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid, o_xfer_wdata,
           o_xfer_addr, o_xfer_size, o_xfer_dav, o_xfer_trig, o_xfer_en,
           o_xfer_write, o_xfer_prot, o_xfer_lock, o_xfer_full, o_busy, o_done
  );

endinterface

// File: rtl/ahb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: o_data always shows the head entry.
// Push on a full FIFO is accepted only when a pop frees the slot in the same cycle.
module ahb_sync_fifo #(
  parameter int WDT   = 32,
  parameter int DEPTH = 8
) (
  input  logic                     i_hclk,
  input  logic                     i_hreset_n,
  input  logic                     i_push,
  input  logic [WDT-1:0]           i_data,
  input  logic                     i_pop,
  output logic [WDT-1:0]           o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WDT-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

  // NOTE: storage has no reset; an entry is only ever read once r_count covers it.
  always_ff @(posedge i_hclk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ahb_xfer_sequencer.sv
// Turns one burst command into a beat-by-beat drive of the AHB master UI,
// buffering write data and returned read data in two FWFT FIFOs.
module ahb_xfer_sequencer
  import ahb_master_pkg::*;
#(
  parameter int BUS_WDT    = 32,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic                 i_hclk,
  input logic                 i_hreset_n,
  ahb_xfer_sequencer_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // One slot stays free for the data phase already on the bus when issue stops.
  localparam logic [CW-1:0] FULL_THR = CW'(FIFO_DEPTH - 1);

  seq_state_e          r_state;
  seq_cmd_t            r_cmd;
  logic [CNT_WDT-1:0]  r_iss_cnt;
  logic [CNT_WDT-1:0]  r_rcv_cnt;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_xfer_en;
  logic                r_xfer_trig;

  logic [BUS_WDT-1:0]  w_wf_head;
  logic [BUS_WDT-1:0]  w_rf_head;
  logic                w_wf_full;
  logic                w_wf_empty;
  logic                w_rf_full;
  logic                w_rf_empty;
  logic [CW-1:0]       w_wf_count;
  logic [CW-1:0]       w_rf_count;
  logic                w_wf_push;
  logic                w_wf_pop;
  logic                w_rf_pop;
  logic                w_xfer_full;
  logic                w_beat_rdy;
  logic                w_beat_issue;
  logic                w_cmd_accept;
  logic                w_rcv_inc;
  logic                w_drain_done;
  logic [CNT_WDT-1:0]  w_iss_next;
  logic [CNT_WDT-1:0]  w_rcv_next;

  ahb_sync_fifo #(.WDT(BUS_WDT), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .i_hclk     (i_hclk),
    .i_hreset_n (i_hreset_n),
    .i_push     (w_wf_push),
    .i_data     (bus.i_wr_data),
    .i_pop      (w_wf_pop),
    .o_data     (w_wf_head),
    .o_full     (w_wf_full),
    .o_empty    (w_wf_empty),
    .o_count    (w_wf_count)
  );

  ahb_sync_fifo #(.WDT(BUS_WDT), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .i_hclk     (i_hclk),
    .i_hreset_n (i_hreset_n),
    .i_push     (bus.i_xfer_rdav),
    .i_data     (bus.i_xfer_rdata),
    .i_pop      (w_rf_pop),
    .o_data     (w_rf_head),
    .o_full     (w_rf_full),
    .o_empty    (w_rf_empty),
    .o_count    (w_rf_count)
  );

  assign w_wf_push    = bus.i_wr_valid && !w_wf_full;
  assign w_rf_pop     = bus.i_rd_ready && !w_rf_empty;
  assign w_xfer_full  = (w_rf_count >= FULL_THR);
  assign w_cmd_accept = bus.i_cmd_valid && r_cmd_ready;

  // A beat leaves only when the master advances and this side can back it with data/space.
  assign w_beat_rdy   = r_cmd.write ? !w_wf_empty : !w_xfer_full;
  assign w_beat_issue = r_xfer_en && bus.i_xfer_adv && w_beat_rdy;
  assign w_wf_pop     = w_beat_issue && r_cmd.write;

  assign w_iss_next   = r_iss_cnt + 1'b1;
  assign w_rcv_inc    = bus.i_xfer_rdav && (r_rcv_cnt != '1);
  assign w_rcv_next   = r_rcv_cnt + CNT_WDT'(w_rcv_inc);
  assign w_drain_done = r_cmd.write ? bus.i_xfer_adv : (w_rcv_next == r_cmd.len);

  // NOTE: every register here uses <= so each branch sees pre-edge values of the others.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_iss_cnt   <= '0;
      r_rcv_cnt   <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_xfer_en   <= 1'b0;
      r_xfer_trig <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_rcv_cnt <= w_rcv_next;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_accept) begin
            r_cmd <= '{addr:  bus.i_cmd_addr,
                       len:   bus.i_cmd_len,
                       size:  bus.i_cmd_size,
                       write: bus.i_cmd_write,
                       prot:  bus.i_cmd_prot,
                       lock:  bus.i_cmd_lock};
            r_iss_cnt <= '0;
            r_rcv_cnt <= '0;
            if (bus.i_cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= ST_TRIG;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_xfer_en   <= 1'b1;
              r_xfer_trig <= 1'b1;
            end
          end
        end
        ST_TRIG, ST_RUN: begin
          if (w_beat_issue) begin
            r_iss_cnt   <= w_iss_next;
            r_xfer_trig <= 1'b0;
            if (w_iss_next == r_cmd.len) begin
              r_state   <= ST_DRAIN;
              r_xfer_en <= 1'b0;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_DRAIN: begin
          // Writes wait out the last data phase; reads wait for every beat's data.
          if (w_drain_done) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready  = r_cmd_ready;
  assign bus.o_wr_ready   = !w_wf_full;
  assign bus.o_rd_data    = w_rf_head;
  assign bus.o_rd_valid   = !w_rf_empty;
  assign bus.o_xfer_wdata = w_wf_head;
  assign bus.o_xfer_addr  = r_cmd.addr;
  assign bus.o_xfer_size  = r_cmd.size;
  assign bus.o_xfer_dav   = !w_wf_empty;
  assign bus.o_xfer_trig  = r_xfer_trig;
  assign bus.o_xfer_en    = r_xfer_en;
  assign bus.o_xfer_write = r_cmd.write;
  assign bus.o_xfer_prot  = r_cmd.prot;
  assign bus.o_xfer_lock  = r_cmd.lock;
  assign bus.o_xfer_full  = w_xfer_full;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;

  // The master must never return data the read FIFO cannot hold.
  a_rd_no_overflow: assert property (@(posedge i_hclk) disable iff (!i_hreset_n)
    bus.i_xfer_rdav |-> (!w_rf_full || w_rf_pop));

  a_wr_no_underflow: assert property (@(posedge i_hclk) disable iff (!i_hreset_n)
    w_wf_pop |-> (w_wf_count != '0));

endmodule

// File: tb/tb_ahb_xfer_sequencer.sv
// Scoreboarded bench for ahb_xfer_sequencer: a simple AHB master model returns
// read data one cycle after each issued read beat; queues hold expected data.
module tb_ahb_xfer_sequencer;

  localparam int BUS_WDT = 32;
  localparam int DEPTH   = 8;

  logic i_hclk     = 1'b0;
  logic i_hreset_n = 1'b0;
  always #5 i_hclk = ~i_hclk;

  ahb_xfer_sequencer_if #(.BUS_WDT(BUS_WDT)) bus ();

  ahb_xfer_sequencer #(.BUS_WDT(BUS_WDT), .FIFO_DEPTH(DEPTH)) dut (
    .i_hclk     (i_hclk),
    .i_hreset_n (i_hreset_n),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t_acc    = 0;

  logic [BUS_WDT-1:0] wq[$];
  logic [BUS_WDT-1:0] rq[$];
  int  wbeats, rbeats, rdavs, rpops, rd_occ;
  bit  rd_pending, en_seen;

  always @(posedge i_hclk) cyc++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Master model and scoreboard; evaluates just after each falling edge the
  // handshakes that the next rising edge will take.
  initial begin
    bit rpop;
    bus.i_xfer_rdav  = 1'b0;
    bus.i_xfer_rdata = '0;
    rd_pending = 1'b0;
    forever begin
      @(negedge i_hclk);
      #1;
      if (!i_hreset_n) begin
        wq.delete();
        rq.delete();
        rd_occ = 0;
        rd_pending = 1'b0;
        bus.i_xfer_rdav = 1'b0;
        continue;
      end
      bus.i_xfer_rdav = rd_pending;
      if (rd_pending) begin
        bus.i_xfer_rdata = $urandom;
        rq.push_back(bus.i_xfer_rdata);
        rdavs++;
      end
      rd_pending = 1'b0;
      check("xfer_full", bus.o_xfer_full, rd_occ >= DEPTH - 1);
      check("rd_valid", bus.o_rd_valid, rd_occ != 0);
      check("xfer_dav", bus.o_xfer_dav, wq.size() != 0);
      check("wr_ready", bus.o_wr_ready, wq.size() < DEPTH);
      if (bus.o_xfer_en) en_seen = 1'b1;
      if (bus.o_xfer_en && bus.i_xfer_adv) begin
        if (bus.o_xfer_write) begin
          if (bus.o_xfer_dav) begin
            wbeats++;
            if (wq.size() == 0) check("wq_empty", 1, 0);
            else check("wdata", bus.o_xfer_wdata, wq.pop_front());
          end
        end else if (!bus.o_xfer_full) begin
          rbeats++;
          rd_pending = 1'b1;
        end
      end
      if (bus.i_wr_valid && bus.o_wr_ready) wq.push_back(bus.i_wr_data);
      rpop = bus.o_rd_valid && bus.i_rd_ready;
      if (rpop) begin
        rpops++;
        if (rq.size() == 0) check("rq_empty", 1, 0);
        else check("rdata", bus.o_rd_data, rq.pop_front());
      end
      rd_occ = rd_occ + (bus.i_xfer_rdav ? 1 : 0) - (rpop ? 1 : 0);
    end
  end

  task automatic clr_counts();
    wbeats = 0; rbeats = 0; rdavs = 0; rpops = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, bus.o_cmd_ready, 1);
    check({tag, "_wr_ready"},  bus.o_wr_ready, 1);
    check({tag, "_busy"},      bus.o_busy, 0);
    check({tag, "_done"},      bus.o_done, 0);
    check({tag, "_en"},        bus.o_xfer_en, 0);
    check({tag, "_trig"},      bus.o_xfer_trig, 0);
    check({tag, "_rd_valid"},  bus.o_rd_valid, 0);
    check({tag, "_dav"},       bus.o_xfer_dav, 0);
    check({tag, "_full"},      bus.o_xfer_full, 0);
    check({tag, "_addr"},      bus.o_xfer_addr, 0);
    check({tag, "_size"},      bus.o_xfer_size, 0);
    check({tag, "_write"},     bus.o_xfer_write, 0);
    check({tag, "_prot"},      bus.o_xfer_prot, 0);
    check({tag, "_lock"},      bus.o_xfer_lock, 0);
  endtask

  task automatic push_wr(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = base + 32'(i);
      @(negedge i_hclk);
    end
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [15:0] len,
                          input logic [1:0] size, input logic wr,
                          input logic [3:0] prot, input logic lock);
    int k = 0;
    while (!bus.o_cmd_ready) begin
      @(negedge i_hclk);
      if (++k > 500) begin
        check("cmd_ready_timeout", 0, 1);
        return;
      end
    end
    bus.i_cmd_addr  = addr;
    bus.i_cmd_len   = len;
    bus.i_cmd_size  = size;
    bus.i_cmd_write = wr;
    bus.i_cmd_prot  = prot;
    bus.i_cmd_lock  = lock;
    bus.i_cmd_valid = 1'b1;
    @(negedge i_hclk);
    bus.i_cmd_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = -1;
    for (int k = 0; k < 2000; k++) begin
      if (bus.o_done) begin
        lat = cyc - t_acc;
        return;
      end
      @(negedge i_hclk);
    end
    check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic drain_rd(input string tag, input int exp_pops);
    bus.i_rd_ready = 1'b1;
    for (int k = 0; k < 100 && (bus.o_rd_valid || rq.size() != 0); k++) @(negedge i_hclk);
    check({tag, "_pops"}, rpops, exp_pops);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_addr  = '0;
    bus.i_cmd_len   = '0;
    bus.i_cmd_size  = '0;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_prot  = '0;
    bus.i_cmd_lock  = 1'b0;
    bus.i_wr_data   = '0;
    bus.i_wr_valid  = 1'b0;
    bus.i_rd_ready  = 1'b1;
    bus.i_xfer_adv  = 1'b1;
    clr_counts();

    repeat (3) @(negedge i_hclk);
    check_idle("por");
    i_hreset_n = 1'b1;
    @(negedge i_hclk);

    // Write burst of 4 with data preloaded.
    push_wr(4, 32'hA000_0000);
    clr_counts();
    send_cmd(32'h100, 16'd4, 2'd2, 1'b1, 4'h3, 1'b0);
    check("t1_trig", bus.o_xfer_trig, 1);
    check("t1_en", bus.o_xfer_en, 1);
    check("t1_addr", bus.o_xfer_addr, 32'h100);
    check("t1_size", bus.o_xfer_size, 2);
    check("t1_prot", bus.o_xfer_prot, 3);
    check("t1_busy", bus.o_busy, 1);
    check("t1_cmd_ready", bus.o_cmd_ready, 0);
    @(negedge i_hclk);
    check("t1_trig_1cyc", bus.o_xfer_trig, 0);
    check("t1_en_run", bus.o_xfer_en, 1);
    check("t1_write_hold", bus.o_xfer_write, 1);
    wait_done("t1", lat);
    check("t1_done_lat", lat, 5);
    check("t1_beats", wbeats, 4);
    check("t1_en_drain", bus.o_xfer_en, 0);
    @(negedge i_hclk);
    check("t1_done_pulse", bus.o_done, 0);

    // Write burst of 3 that runs dry after the first beat.
    push_wr(1, 32'hB000_0000);
    clr_counts();
    send_cmd(32'h200, 16'd3, 2'd2, 1'b1, 4'h0, 1'b1);
    check("t2_dav_trig", bus.o_xfer_dav, 1);
    @(negedge i_hclk);
    check("t2_dav_dry", bus.o_xfer_dav, 0);
    check("t2_lock", bus.o_xfer_lock, 1);
    repeat (2) @(negedge i_hclk);
    check("t2_stall_beats", wbeats, 1);
    check("t2_stall_en", bus.o_xfer_en, 1);
    push_wr(2, 32'hB000_0001);
    wait_done("t2", lat);
    check("t2_beats", wbeats, 3);

    // Zero-length command.
    @(negedge i_hclk);
    en_seen = 1'b0;
    send_cmd(32'h300, 16'd0, 2'd1, 1'b0, 4'h1, 1'b0);
    check("t3_done", bus.o_done, 1);
    check("t3_busy", bus.o_busy, 0);
    check("t3_cmd_ready", bus.o_cmd_ready, 1);
    @(negedge i_hclk);
    check("t3_done_pulse", bus.o_done, 0);
    repeat (2) @(negedge i_hclk);
    check("t3_en_never", en_seen, 0);

    // Read burst of 8 against a stalled consumer.
    clr_counts();
    bus.i_rd_ready = 1'b0;
    send_cmd(32'h400, 16'd8, 2'd2, 1'b0, 4'h0, 1'b0);
    wait_done("t4", lat);
    check("t4_beats", rbeats, 8);
    check("t4_rdavs", rdavs, 8);
    check("t4_full", bus.o_xfer_full, 1);
    check("t4_pops_held", rpops, 0);
    drain_rd("t4", 8);

    // Read burst of 6 with a three-cycle RETRY stall.
    clr_counts();
    send_cmd(32'h500, 16'd6, 2'd2, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 50 && rbeats < 2; k++) @(negedge i_hclk);
    r0 = rbeats;
    check("t5_pre_stall", r0, 2);
    bus.i_xfer_adv = 1'b0;
    repeat (3) @(negedge i_hclk);
    check("t5_frozen", rbeats, r0);
    check("t5_en_stall", bus.o_xfer_en, 1);
    bus.i_xfer_adv = 1'b1;
    wait_done("t5", lat);
    check("t5_beats", rbeats, 6);
    check("t5_rdavs", rdavs, 6);
    drain_rd("t5", 6);

    // Reset in the middle of a write burst, then a fresh read.
    push_wr(4, 32'hC000_0000);
    clr_counts();
    send_cmd(32'h600, 16'd4, 2'd2, 1'b1, 4'h5, 1'b1);
    for (int k = 0; k < 50 && wbeats < 1; k++) @(negedge i_hclk);
    i_hreset_n = 1'b0;
    @(negedge i_hclk);
    check_idle("t6_rst");
    check("t6_beats_cut", wbeats, 1);
    i_hreset_n = 1'b1;
    clr_counts();
    send_cmd(32'h700, 16'd3, 2'd1, 1'b0, 4'h2, 1'b0);
    check("t6_trig", bus.o_xfer_trig, 1);
    check("t6_addr", bus.o_xfer_addr, 32'h700);
    wait_done("t6", lat);
    check("t6_done_lat", lat, 4);
    check("t6_beats", rbeats, 3);
    drain_rd("t6", 3);

    repeat (2) @(negedge i_hclk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
